// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared FSM states, counter width and the extend-and-multiply helper
package mult_share_pkg;
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
    localparam int OPCNT_W = 16;
    localparam int MAXW = 32;
    // Operands arrive zero-padded to MAXW; w is the real operand width used for sign extension
    function automatic logic [2*MAXW-1:0] mul_ext(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                                                  input logic signed_mode, input int w);
        logic [2*MAXW-1:0] ea;
        logic [2*MAXW-1:0] eb;
        ea = {{MAXW{1'b0}}, a};
        eb = {{MAXW{1'b0}}, b};
        if (signed_mode && a[w-1]) ea = ea | ({2*MAXW{1'b1}} << w);
        if (signed_mode && b[w-1]) eb = eb | ({2*MAXW{1'b1}} << w);
        return ea * eb;
    endfunction
endpackage

// File: rtl/mult_share_arbiter_rr.sv
// rr_arbiter: round-robin grant over req, searching from last+1; the caller owns the pointer register
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic          advance,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic [IW-1:0] next_ptr
);
    int c;
    logic found;
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        c = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last) + k) % N;
            if (enable && !found && req[c]) begin
                found = 1'b1;
                grant[c] = 1'b1;
                idx = IW'(c);
            end
        end
    end
    assign next_ptr = advance ? idx : last;
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: one shared WIDTH x WIDTH multiplier served round-robin to NREQ requesters
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_signed,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_signed,
    output logic                    busy,
    output logic [OPCNT_W-1:0]      op_count
);
    localparam int PW = 2 * WIDTH;
    state_t state_q, state_d;
    logic [IDW-1:0] last_q, last_d, id_q, id_d, grant_idx, next_ptr;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic sgn_q, sgn_d;
    logic [PW-1:0] prod_q, prod_d;
    logic [OPCNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] grant;
    logic accept;

    // reset gates enable so no grant is ever offered while reset is held
    rr_arbiter #(.N(NREQ)) u_arb (
        .req      (req_valid),
        .enable   (state_q == IDLE && reset),
        .advance  (accept),
        .last     (last_q),
        .grant    (grant),
        .idx      (grant_idx),
        .next_ptr (next_ptr)
    );

    assign accept = |(req_valid & grant);

    always_comb begin
        state_d = state_q;
        last_d = next_ptr;
        id_d = id_q;
        a_d = a_q;
        b_d = b_q;
        sgn_d = sgn_q;
        prod_d = prod_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = MUL;
                id_d = grant_idx;
                a_d = req_a[grant_idx*WIDTH +: WIDTH];
                b_d = req_b[grant_idx*WIDTH +: WIDTH];
                sgn_d = req_signed[grant_idx];
            end
            MUL: begin
                state_d = RESP;
                prod_d = PW'(mul_ext(MAXW'(a_q), MAXW'(b_q), sgn_q, WIDTH));
            end
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q <= IDW'(NREQ - 1);
            id_q <= '0;
            a_q <= '0;
            b_q <= '0;
            sgn_q <= 1'b0;
            prod_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            id_q <= id_d;
            a_q <= a_d;
            b_q <= b_d;
            sgn_q <= sgn_d;
            prod_q <= prod_d;
            cnt_q <= cnt_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = state_q == RESP;
    assign rsp_product = prod_q;
    assign rsp_id = id_q;
    assign rsp_signed = sgn_q;
    assign busy = state_q != IDLE;
    assign op_count = cnt_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: scoreboard bench with a transaction-level model of grants, latency and products
module tb_mult_share_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_signed = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [2*W-1:0] rsp_product;
    logic [IW-1:0] rsp_id;
    logic rsp_signed;
    logic busy;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_signed  (req_signed),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .rsp_signed  (rsp_signed),
        .busy        (busy),
        .op_count    (op_count)
    );

    typedef struct {
        int id;
        int prod;
        int sgn;
    } exp_t;

    exp_t sb[$];
    bit mon_en = 1'b0;
    bit preload = 1'b0;
    logic [N-1:0] hs = '0;
    int m_out = 0;
    int m_phase = 0;
    int m_last = N - 1;
    int m_cnt = 0;
    int m_rst = 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_mul(input int a, input int b, input int s);
        int x;
        int y;
        x = a;
        y = b;
        if (s != 0) begin
            if (x >= 128) x -= 256;
            if (y >= 128) y -= 256;
        end
        return (x * y) & 'hFFFF;
    endfunction

    // Monitor: compare the current cycle against the model, then advance the model across the next edge
    always @(negedge clk) begin
        if (mon_en) begin
            int g;
            int er;
            if (preload) begin
                m_cnt = 'hFFFD;
                preload = 1'b0;
            end
            g = -1;
            if (reset && m_out == 0)
                for (int k = 1; k <= N; k++)
                    if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            er = (g < 0) ? 0 : (1 << g);
            chk("req_ready", int'(req_ready), er);
            chk("busy", int'(busy), m_out);
            chk("rsp_valid", int'(rsp_valid), int'(m_phase == 2));
            chk("op_count", int'(op_count), m_cnt);
            if (m_rst != 0) begin
                chk("rst_product", int'(rsp_product), 0);
                chk("rst_id", int'(rsp_id), 0);
                chk("rst_signed", int'(rsp_signed), 0);
            end
            if (m_phase == 2) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end else begin
                    chk("rsp_product", int'(rsp_product), sb[0].prod);
                    chk("rsp_id", int'(rsp_id), sb[0].id);
                    chk("rsp_signed", int'(rsp_signed), sb[0].sgn);
                end
            end
            hs = req_valid & req_ready;
            if (!reset) begin
                m_out = 0;
                m_phase = 0;
                m_last = N - 1;
                m_cnt = 0;
                m_rst = 1;
                sb.delete();
            end else begin
                m_rst = 0;
                if (g >= 0) begin
                    sb.push_back('{g, ref_mul(int'(req_a[g*W +: W]), int'(req_b[g*W +: W]), int'(req_signed[g])),
                                   int'(req_signed[g])});
                    m_last = g;
                    m_out = 1;
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else if (m_phase == 2 && rsp_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    m_cnt = (m_cnt + 1) % 65536;
                    m_out = 0;
                    m_phase = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
    endtask

    task automatic issue(input int i, input int a, input int b, input int s);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req_signed[i] = s[0];
        req_valid[i] = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != '0 || busy) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: req_valid=%b busy=%b", req_valid, busy);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        tick();
        reset = 1'b1;

        issue(0, 'h03, 'h05, 0);
        drain();
        chk("first_op_count", int'(op_count), 1);

        issue(1, 'h80, 'h80, 1);
        drain();
        issue(2, 'hFF, 'hFF, 1);
        drain();
        issue(3, 'hFF, 'hFF, 0);
        drain();
        issue(0, 'h80, 'h01, 1);
        drain();

        pulse_reset();
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i]) issue(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
            tick();
        end
        drain();

        rsp_ready = 1'b0;
        issue(1, 'h7F, 'h81, 1);
        tick();
        issue(2, 'h12, 'h34, 0);
        repeat (12) tick();
        rsp_ready = 1'b1;
        drain();

        issue(1, 7, 9, 0);
        tick();
        issue(2, 'hC3, 'h3C, 1);
        pulse_reset();
        drain();

        for (int c = 0; c < 2500; c++) begin
            rsp_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    issue(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
            tick();
        end
        rsp_ready = 1'b1;
        drain();

        force dut.cnt_q = 16'hFFFD;
        preload = 1'b1;
        #2;
        release dut.cnt_q;
        for (int i = 0; i < N; i++) begin
            issue(i, i + 1, 'hF0, i % 2);
            drain();
        end
        chk("wrap_op_count", int'(op_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
